spi_minion_multichannel_adapter: RTL
====================================

# spi_minion_multichannel_adapter

Parametrised SPI minion with a multi-channel stream adapter. A single SPI link is multiplexed onto N_CHANNELS independent val/rdy stream pairs, each buffered by its own FIFOs. An address field in every SPI packet selects the channel. It extends the single-channel minion/adapter pair with channel routing, frame-length checking, pipelined reads and per-channel overflow flags.

## Interface
Parameters:
- BIT_WIDTH, 8 — payload width per channel
- N_CHANNELS, 4 — stream channel count (≥1)
- N_SAMPLES, 2 — depth of each FIFO (≥2, power of two)
- Derived: CH_BITS = max(1, $clog2(N_CHANNELS)); PKT_BITS = BIT_WIDTH + CH_BITS + 2

Ports:
- clk  in  1  system clock; sole clock, all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- cs  in  1  SPI chip select, active-low, asynchronous to clk
- sclk  in  1  SPI clock, asynchronous to clk
- mosi  in  1  SPI data in
- miso  out  1  SPI data out
- recv_msg  in  N_CHANNELS*BIT_WIDTH  core→SPI data; channel c at [c*BIT_WIDTH +: BIT_WIDTH]
- recv_val  in  N_CHANNELS  per-channel valid
- recv_rdy  out  N_CHANNELS  per-channel ready (= recv FIFO not full)
- send_msg  out  N_CHANNELS*BIT_WIDTH  SPI→core data, same packing
- send_val  out  N_CHANNELS  per-channel valid (= send FIFO not empty)
- send_rdy  in  N_CHANNELS  per-channel ready
- overflow  out  N_CHANNELS  sticky: write dropped because the send FIFO was full
- frame_err  out  1  one-cycle pulse when a frame of the wrong length ends

## Operation
- Inputs cs, sclk and mosi each pass through a 2-flop synchroniser. Edges are detected on the synchronised values.
- SPI mode 0, MSB first. mosi is sampled on sclk rise; miso is updated on sclk fall.
- Request packet (mosi), MSB→LSB: {wr, rd, chan[CH_BITS], data[BIT_WIDTH]}.
- Response packet (miso): {val, spc, chan[CH_BITS], data[BIT_WIDTH]}.
- Frame controller states:
  - IDLE: cs high.
  - LOAD: one cycle after a cs fall is detected. Loads the response into the shift register and performs the pull.
  - SHIFT: shifts one bit per sclk rise. The bit counter saturates at PKT_BITS+1.
  - DONE: one cycle after a cs rise is detected. If the count == PKT_BITS, push. Otherwise assert frame_err and discard the frame. Then return to IDLE.
- Push:
  - wr=1: enqueue data into send FIFO[chan] if that FIFO is not full. If it is full, drop the data and set overflow[chan].
  - rd=1: set rd_pend and latch rd_chan = chan.
  - Always latch last_chan = chan.
- Pull (in LOAD):
  - If rd_pend and recv FIFO[rd_chan] is non-empty: val=1, data=head, chan=rd_chan, and dequeue.
  - Otherwise: val=0, data=0, chan=rd_chan.
  - spc = !full(send FIFO[last_chan]).
  - rd_pend is cleared.
  - Read data therefore returns in the frame after the one carrying rd=1.
- Core side: standard val/rdy. A transfer occurs on a cycle where val && rdy. send_msg is zero when its FIFO is empty.
- Out-of-range chan (≥ N_CHANNELS): writes are dropped with no flag; reads return val=0.

## Timing
- Reset values: miso=0, send_val=0, send_msg=0, recv_rdy=all 1 (first cycle after reset), overflow=0, frame_err=0.
- Reset also clears: all FIFOs, rd_pend=0, rd_chan=0, last_chan=0, state=IDLE.
- Reset mid-frame: the controller ignores SPI activity until a cs high→low transition is seen after reset.
- SPI rate limit: sclk high and low phases must each be ≥4 clk periods. cs setup to the first sclk rise must be ≥6 clk periods.
- miso: the MSB of the response is driven 4 clk cycles after the cs fall (2 sync + detect + LOAD).
- Push latency: send_val[c] rises 4 clk cycles after the cs rise (2 sync + detect + DONE).
- Full-boundary rule: full/empty checks use the state at the start of the cycle.
  - A push to a full send FIFO is dropped even if the core dequeues in the same cycle.
  - A pull and a core enqueue on the same recv FIFO in the same cycle are both honoured.
- FIFO pointers wrap modulo N_SAMPLES. A full/empty distinction bit is required.

## Structure
- Package spi_minion_mc_pkg holds:
  - CH_BITS and PKT_BITS functions
  - field-offset localparams (WR_BIT, RD_BIT, CHAN_LSB)
  - frame-state enum {IDLE, LOAD, SHIFT, DONE}
- Sub-module spi_minion_mc_fifo (parametrised width/depth, val/rdy both sides) is instantiated 2×N_CHANNELS via generate.
- The shift register and frame controller stay in the top module.

## Test plan
Configuration for all scenarios: BIT_WIDTH=8, N_CHANNELS=4, N_SAMPLES=2, PKT_BITS=12.

1. Write frame 0b1_0_10_10100101, send_rdy=1 → send_val[2]=1 with send_msg[2]=0xA5 for one cycle; other channels idle; response spc=1.
2. Three writes to channel 1 with send_rdy[1]=0 → first two are queued; third is dropped and overflow[1]=1; next frame reports spc=0; after draining, overflow[1] stays 1 until reset.
3. Core enqueues 0x3C on recv channel 3; frame rd=1, chan=3; then an idle frame → second response = {1,1,11,0x3C}; recv_rdy[3] remains 1.
4. Read request on empty channel 0 → next response val=0, data=0x00; rd_pend cleared, so a following idle frame also returns val=0.
5. Frame of 11 sclk edges with wr=1 → frame_err pulses once; no send_val; next well-formed 12-bit frame is accepted normally.
6. reset=0 asserted mid-SHIFT after 5 bits, then released while cs is still low → no push and miso=0; a fresh cs cycle then completes a write correctly.

Source files
------------

// File: rtl/spi_minion_mc_pkg.sv
// Shared sizing helpers, packet field offsets and frame states for the multichannel SPI minion.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package spi_minion_mc_pkg;

    function automatic int ch_bits(input int n_channels);
        return (n_channels <= 2) ? 1 : $clog2(n_channels);
    endfunction

    function automatic int pkt_bits(input int bit_width, input int n_channels);
        return bit_width + ch_bits(n_channels) + 2;
    endfunction

    // WR_BIT/RD_BIT count down from the packet width; CHAN_LSB counts up from the top of the data field.
    localparam int WR_BIT   = 1;
    localparam int RD_BIT   = 2;
    localparam int CHAN_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } frame_state_t;

endpackage

// File: rtl/spi_minion_mc_fifo.sv
// Power-of-two circular FIFO with val/rdy on both sides; head is zero while empty.
// Latency: an enqueued word is visible at the head the cycle after the write.
// Backpressure: enq_rdy drops while full; full/empty use start-of-cycle pointers only.
module spi_minion_mc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] enq_msg,
    input  logic             enq_val,
    output logic             enq_rdy,
    output logic [WIDTH-1:0] deq_msg,
    output logic             deq_val,
    input  logic             deq_rdy
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;

    // The extra pointer bit separates full from empty when the indices coincide.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign enq_rdy = !full;
    assign deq_val = !empty;
    assign deq_msg = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_val && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq_val && deq_rdy)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_val && !full)
            mem[wr_ptr[AW-1:0]] <= enq_msg;
    end

endmodule

// File: rtl/spi_minion_multichannel_adapter.sv
// SPI mode-0 minion multiplexing one link onto N val/rdy channel pairs, addressed per frame.
// Latency: miso MSB 4 clk after cs fall; send_val 4 clk after cs rise; read data returns one frame later.
// Backpressure: full send FIFO drops the write and sets sticky overflow; spc reports room on last channel.
module spi_minion_multichannel_adapter
    import spi_minion_mc_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int N_CHANNELS = 4,
    parameter int N_SAMPLES  = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cs,
    input  logic                            sclk,
    input  logic                            mosi,
    output logic                            miso,
    input  logic [N_CHANNELS*BIT_WIDTH-1:0] recv_msg,
    input  logic [N_CHANNELS-1:0]           recv_val,
    output logic [N_CHANNELS-1:0]           recv_rdy,
    output logic [N_CHANNELS*BIT_WIDTH-1:0] send_msg,
    output logic [N_CHANNELS-1:0]           send_val,
    input  logic [N_CHANNELS-1:0]           send_rdy,
    output logic [N_CHANNELS-1:0]           overflow,
    output logic                            frame_err
);
    localparam int CHB   = ch_bits(N_CHANNELS);
    localparam int PKTB  = pkt_bits(BIT_WIDTH, N_CHANNELS);
    localparam int CNT_W = $clog2(PKTB + 2);

    logic [1:0] cs_sync, sclk_sync, mosi_sync;
    logic       cs_q, sclk_q;
    logic       cs_s, sclk_s, mosi_s;
    logic       cs_fall, sclk_rise, sclk_fall;

    frame_state_t     state;
    logic [CNT_W-1:0] bit_cnt;
    logic [PKTB-1:0]  shreg;
    logic             rd_pend;
    logic [CHB-1:0]   rd_chan;
    logic [CHB-1:0]   last_chan;

    logic                 req_wr, req_rd, push_ok;
    logic [CHB-1:0]       req_chan;
    logic [BIT_WIDTH-1:0] req_data;

    logic [N_CHANNELS-1:0] send_enq_val, send_enq_rdy;
    logic [N_CHANNELS-1:0] recv_deq_val, recv_deq_rdy;
    logic [BIT_WIDTH-1:0]  recv_deq_msg [N_CHANNELS];

    logic                 head_val, spc, resp_val;
    logic [BIT_WIDTH-1:0] head_dat;
    logic [PKTB-1:0]      resp;

    // Sync flops clear to 0 so a frame cut by reset is not restarted: only a fresh high->low cs counts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_q      <= 1'b0;
            sclk_q    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], cs};
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_q      <= cs_s;
            sclk_q    <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[1];
    assign sclk_s    = sclk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign cs_fall   = cs_q && !cs_s;
    assign sclk_rise = !sclk_q && sclk_s;
    assign sclk_fall = sclk_q && !sclk_s;

    assign req_wr   = shreg[PKTB-WR_BIT];
    assign req_rd   = shreg[PKTB-RD_BIT];
    assign req_chan = shreg[BIT_WIDTH+CHAN_LSB +: CHB];
    assign req_data = shreg[BIT_WIDTH-1:0];
    assign push_ok  = (state == DONE) && (bit_cnt == CNT_W'(PKTB));

    always_comb begin
        head_val = 1'b0;
        head_dat = '0;
        spc      = 1'b1;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (rd_chan == CHB'(c)) begin
                head_val = recv_deq_val[c];
                head_dat = recv_deq_msg[c];
            end
            if (last_chan == CHB'(c))
                spc = send_enq_rdy[c];
        end
    end

    assign resp_val = rd_pend && head_val;
    assign resp     = {resp_val, spc, rd_chan, resp_val ? head_dat : {BIT_WIDTH{1'b0}}};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            miso      <= 1'b0;
            frame_err <= 1'b0;
            rd_pend   <= 1'b0;
            rd_chan   <= '0;
            last_chan <= '0;
            overflow  <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall)
                        state <= LOAD;
                end
                LOAD: begin
                    shreg   <= resp;
                    miso    <= resp[PKTB-1];
                    bit_cnt <= '0;
                    rd_pend <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (cs_s) begin
                        state <= DONE;
                    end else begin
                        if (sclk_rise) begin
                            shreg <= {shreg[PKTB-2:0], mosi_s};
                            if (bit_cnt != CNT_W'(PKTB + 1))
                                bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (sclk_fall)
                            miso <= shreg[PKTB-1];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    miso  <= 1'b0;
                    if (bit_cnt == CNT_W'(PKTB)) begin
                        last_chan <= req_chan;
                        if (req_rd) begin
                            rd_pend <= 1'b1;
                            rd_chan <= req_chan;
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            for (int c = 0; c < N_CHANNELS; c++) begin
                if (send_enq_val[c] && !send_enq_rdy[c])
                    overflow[c] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
        assign send_enq_val[g] = push_ok && req_wr && (req_chan == CHB'(g));
        assign recv_deq_rdy[g] = (state == LOAD) && rd_pend && (rd_chan == CHB'(g));

        spi_minion_mc_fifo #(.WIDTH(BIT_WIDTH), .DEPTH(N_SAMPLES)) u_send_fifo (
            .clk     (clk),
            .reset   (reset),
            .enq_msg (req_data),
            .enq_val (send_enq_val[g]),
            .enq_rdy (send_enq_rdy[g]),
            .deq_msg (send_msg[g*BIT_WIDTH +: BIT_WIDTH]),
            .deq_val (send_val[g]),
            .deq_rdy (send_rdy[g])
        );

        spi_minion_mc_fifo #(.WIDTH(BIT_WIDTH), .DEPTH(N_SAMPLES)) u_recv_fifo (
            .clk     (clk),
            .reset   (reset),
            .enq_msg (recv_msg[g*BIT_WIDTH +: BIT_WIDTH]),
            .enq_val (recv_val[g]),
            .enq_rdy (recv_rdy[g]),
            .deq_msg (recv_deq_msg[g]),
            .deq_val (recv_deq_val[g]),
            .deq_rdy (recv_deq_rdy[g])
        );
    end

endmodule
